kernel_bc_fifo_wr_arb: RTL

Round-robin write arbiter that shares one `if_*`-style FIFO write port among `NUM_REQ` producers in the kernel_bc datapath. Each producer sees its own write/full_n handshake. The arbiter grants at most one producer per cycle, using burst-limited round-robin priority. The granted word is captured into a single output register that drives the shared FIFO's `if_write`/`if_din`.

---
 rtl/kernel_bc_fifo_wr_arb_if.sv | 27 ++
 rtl/kernel_bc_fifo_wr_arb.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/kernel_bc_fifo_wr_arb_if.sv
// Shared-FIFO write arbiter bus: per-producer write/full_n handshakes plus the FIFO write port.
interface kernel_bc_fifo_wr_arb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned REQ_BITS   = 2
);
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
    logic [NUM_REQ-1:0]            req_full_n;
    logic                          fifo_write;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          fifo_full_n;
    logic [REQ_BITS-1:0]           grant_src;
    logic                          busy;

    // Producers and FIFO side (testbench / surrounding datapath)
    modport master (
        output req_write, req_din, fifo_full_n,
        input  req_full_n, fifo_write, fifo_din, grant_src, busy
    );

    // Arbiter side
    modport slave (
        input  req_write, req_din, fifo_full_n,
        output req_full_n, fifo_write, fifo_din, grant_src, busy
    );
endinterface

// File: rtl/kernel_bc_fifo_wr_arb.sv
// Burst-limited round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
module kernel_bc_fifo_wr_arb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned REQ_BITS   = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    kernel_bc_fifo_wr_arb_if.slave bus
);
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    typedef enum logic [0:0] {ST_IDLE, ST_OWNED} state_t;

    state_t                state_q, state_d;
    logic [REQ_BITS-1:0]   own_q, own_d;
    logic [REQ_BITS-1:0]   ptr_q, ptr_d;
    logic [3:0]            bcnt_q, bcnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [REQ_BITS-1:0]   out_src_q, out_src_d;
    logic                  busy_q, busy_d;

    logic                  can_accept;
    logic                  grant;
    logic                  scan;
    logic                  found;
    logic [REQ_BITS-1:0]   scan_base;
    logic [REQ_BITS-1:0]   idx;
    logic [REQ_BITS-1:0]   gidx;
    logic [NUM_REQ-1:0]    req_full_n_c;

    // Producer index arithmetic modulo NUM_REQ; both operands are below NUM_REQ.
    function automatic logic [REQ_BITS-1:0] wrap_add(input logic [REQ_BITS-1:0] base,
                                                     input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return REQ_BITS'(s);
    endfunction

    // Next-state, grant selection and output-register update.
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        ptr_d       = ptr_q;
        bcnt_d      = bcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        grant       = 1'b0;
        scan        = 1'b0;
        found       = 1'b0;
        scan_base   = ptr_q;
        idx         = '0;
        gidx        = '0;

        can_accept = ~out_valid_q | bus.fifo_full_n;

        if (can_accept) begin
            if (state_q == ST_OWNED) begin
                if (bus.req_write[own_q]) begin
                    grant  = 1'b1;
                    gidx   = own_q;
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_d == MAX_B) begin
                        ptr_d   = wrap_add(own_q, 1);
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Owner released early: rescan from the next index this same cycle.
                    ptr_d     = wrap_add(own_q, 1);
                    scan_base = wrap_add(own_q, 1);
                    state_d   = ST_IDLE;
                    scan      = 1'b1;
                end
            end else begin
                scan = 1'b1;
            end

            if (scan) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    idx = wrap_add(scan_base, i);
                    if (!found && bus.req_write[idx]) begin
                        found = 1'b1;
                        gidx  = idx;
                    end
                end
                if (found) begin
                    grant  = 1'b1;
                    bcnt_d = 4'd1;
                    own_d  = gidx;
                    if (MAX_BURST == 1) begin
                        state_d = ST_IDLE;
                        ptr_d   = wrap_add(gidx, 1);
                    end else begin
                        state_d = ST_OWNED;
                    end
                end
            end
        end

        if (grant) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.req_din[gidx*DATA_WIDTH +: DATA_WIDTH];
            out_src_d   = gidx;
        end else if (out_valid_q && bus.fifo_full_n) begin
            out_valid_d = 1'b0;
        end

        busy_d = out_valid_d | (state_d == ST_OWNED);

        req_full_n_c = '0;
        if (grant && reset) req_full_n_c[gidx] = 1'b1;
    end

    // State and output registers; async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            own_q       <= '0;
            ptr_q       <= '0;
            bcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            ptr_q       <= ptr_d;
            bcnt_q      <= bcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_full_n = req_full_n_c;
    assign bus.fifo_write = out_valid_q;
    assign bus.fifo_din   = out_data_q;
    assign bus.grant_src  = out_src_q;
    assign bus.busy       = busy_q;
endmodule
